// File: rtl/tile_pkg.sv
// Shared tile codes, map geometry, restore FSM states and the pristine level image.
package tile_pkg;

    localparam int TILE_W = 4;

    localparam logic [TILE_W-1:0] EMPTY_CODE  = 4'h0;
    localparam logic [TILE_W-1:0] PELLET_CODE = 4'h1;
    localparam logic [TILE_W-1:0] POWER_CODE  = 4'h2;
    localparam logic [TILE_W-1:0] WALL_CODE   = 4'h3;

    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RESTORE = 2'd1,
        ST_FINISH  = 2'd2
    } state_t;

    // Both pellet kinds count towards clearing the level.
    function automatic logic is_pellet(input logic [TILE_W-1:0] code);
        return (code == PELLET_CODE) || (code == POWER_CODE);
    endfunction

    // Pristine level: walled border plus a 20x12 pellet field in the top-left
    // corner (240 pellets), with power pellets on the field's right-hand corners.
    function automatic logic [TILE_W-1:0] pristine_tile(input int unsigned idx,
                                                       input int unsigned cols,
                                                       input int unsigned rows);
        int unsigned col;
        int unsigned row;
        col = idx % cols;
        row = idx / cols;
        if (row == 0 || row == rows - 1 || col == 0 || col == cols - 1)
            return WALL_CODE;
        if (row <= 12 && col <= 20)
            return (col == 20 && (row == 1 || row == 12)) ? POWER_CODE : PELLET_CODE;
        return EMPTY_CODE;
    endfunction

endpackage

// File: rtl/tile_rom.sv
// Read-only pristine level image with a registered (1-cycle) read.
module tile_rom
    import tile_pkg::*;
#(
    parameter int DATA_W = TILE_W,
    parameter int COLS   = MAP_COLS,
    parameter int ROWS   = MAP_ROWS,
    parameter int ADDR_W = $clog2(COLS * ROWS)
)(
    input  logic              Clk,
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] data_o
);

    // Synchronous lookup; the image is pure logic so no load file is needed.
    always_ff @(posedge Clk) begin
        data_o <= DATA_W'(pristine_tile(32'(addr_i), COLS, ROWS));
    end

endmodule

// File: rtl/tile_map_ram.sv
// Multi-read-port working tile map with in-place level restore and live pellet count.
//
//  state      | meaning
//  -----------+---------------------------------------------------------------
//  ST_IDLE    | normal play: reads served, writes honoured
//  ST_RESTORE | issuing ROM index idx_q, writing the previous index into the map
//  ST_FINISH  | writing the final map entry, then restore_done pulses
module tile_map_ram
    import tile_pkg::*;
#(
    parameter int DATA_W = TILE_W,
    parameter int COLS   = MAP_COLS,
    parameter int ROWS   = MAP_ROWS,
    parameter int N_RD   = 8,
    localparam int DEPTH  = COLS * ROWS,
    localparam int ADDR_W = $clog2(DEPTH),
    localparam int CNT_W  = $clog2(DEPTH + 1)
)(
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     restore_req,
    input  logic                     we,
    input  logic [ADDR_W-1:0]        write_address,
    input  logic [DATA_W-1:0]        data_In,
    input  logic [N_RD*ADDR_W-1:0]   read_address,
    output logic [N_RD*DATA_W-1:0]   data_Out,
    output logic                     busy,
    output logic                     restore_done,
    output logic [CNT_W-1:0]         pellets_left,
    output logic                     level_clear
);

    localparam logic [ADDR_W:0]   DEPTH_W  = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic [ADDR_W-1:0]   ld_idx_q, ld_idx_d;
    logic                ld_valid_q, ld_valid_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                done_q, done_d;

    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [DATA_W-1:0]   mem_wd;

    logic [DATA_W-1:0]   rom_data;
    logic [DATA_W-1:0]   wr_old;
    logic                wr_ok;

    tile_rom #(
        .DATA_W (DATA_W),
        .COLS   (COLS),
        .ROWS   (ROWS),
        .ADDR_W (ADDR_W)
    ) u_rom (
        .Clk    (Clk),
        .addr_i (idx_q),
        .data_o (rom_data)
    );

    // A write coinciding with a restore request is dropped: the restore overwrites it anyway.
    assign wr_ok  = (state_q == ST_IDLE) && we && !restore_req &&
                    ({1'b0, write_address} < DEPTH_W);
    assign wr_old = mem_q[write_address];

    // Next-state, restore copy sequencing and pellet count update.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        ld_idx_d   = ld_idx_q;
        ld_valid_d = 1'b0;
        count_d    = count_q;
        done_d     = 1'b0;
        mem_we     = 1'b0;
        mem_wa     = write_address;
        mem_wd     = data_In;
        case (state_q)
            ST_IDLE: begin
                if (restore_req) begin
                    state_d = ST_RESTORE;
                    idx_d   = '0;
                    count_d = '0;
                end else if (wr_ok) begin
                    mem_we = 1'b1;
                    if (is_pellet(TILE_W'(wr_old)) && !is_pellet(TILE_W'(data_In)) &&
                        count_q != '0)
                        count_d = count_q - CNT_W'(1);
                    else if (!is_pellet(TILE_W'(wr_old)) && is_pellet(TILE_W'(data_In)) &&
                             count_q != CNT_MAX)
                        count_d = count_q + CNT_W'(1);
                end
            end
            ST_RESTORE: begin
                ld_valid_d = 1'b1;
                ld_idx_d   = idx_q;
                if (ld_valid_q) begin
                    mem_we = 1'b1;
                    mem_wa = ld_idx_q;
                    mem_wd = rom_data;
                    if (is_pellet(TILE_W'(rom_data)) && count_q != CNT_MAX)
                        count_d = count_q + CNT_W'(1);
                end
                if (idx_q == LAST_IDX)
                    state_d = ST_FINISH;
                else
                    idx_d = idx_q + ADDR_W'(1);
            end
            ST_FINISH: begin
                mem_we = 1'b1;
                mem_wa = ld_idx_q;
                mem_wd = rom_data;
                if (is_pellet(TILE_W'(rom_data)) && count_q != CNT_MAX)
                    count_d = count_q + CNT_W'(1);
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; reset always launches a fresh restore from index 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q    <= ST_RESTORE;
            idx_q      <= '0;
            ld_idx_q   <= '0;
            ld_valid_q <= 1'b0;
            count_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            ld_idx_q   <= ld_idx_d;
            ld_valid_q <= ld_valid_d;
            count_q    <= count_d;
            done_q     <= done_d;
        end
    end

    // Working map storage, single write port shared by play writes and restore.
    always_ff @(posedge Clk) begin
        if (mem_we)
            mem_q[mem_wa] <= mem_wd;
    end

    for (genvar k = 0; k < N_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rd_d;
        logic [DATA_W-1:0] rd_q;

        assign ra = read_address[k*ADDR_W +: ADDR_W];

        // Write-first bypass; out-of-range addresses and busy periods read as empty.
        always_comb begin
            rd_d = DATA_W'(EMPTY_CODE);
            if (state_q == ST_IDLE && {1'b0, ra} < DEPTH_W) begin
                if (wr_ok && write_address == ra)
                    rd_d = data_In;
                else
                    rd_d = mem_q[ra];
            end
        end

        // Registered read data.
        always_ff @(posedge Clk) begin
            if (Reset)
                rd_q <= '0;
            else
                rd_q <= rd_d;
        end

        assign data_Out[k*DATA_W +: DATA_W] = rd_q;
    end

    assign busy         = (state_q != ST_IDLE);
    assign restore_done = done_q;
    assign pellets_left = count_q;
    assign level_clear  = (count_q == '0) && (state_q == ST_IDLE);

endmodule

// File: tb/tb_tile_map_ram.sv
// Directed bench for tile_map_ram with a read-data scoreboard and a reference map model.
module tb_tile_map_ram;

    localparam int DEPTH = 1200;
    localparam int AW    = 11;
    localparam int DW    = 4;
    localparam int NR    = 8;
    localparam int CW    = 11;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req = 1'b0;
    logic             we  = 1'b0;
    logic [AW-1:0]    wa  = '0;
    logic [DW-1:0]    di  = '0;
    logic [NR*AW-1:0] ra  = '0;
    logic [NR*DW-1:0] dout;
    logic             busy;
    logic             done;
    logic [CW-1:0]    pl;
    logic             lvl;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [3:0] mem_m [DEPTH];
    int         cnt_m;
    logic [3:0] exp_q [$];
    int         ra_v [NR];

    always #5 clk = ~clk;

    tile_map_ram dut (
        .Clk           (clk),
        .Reset         (rst),
        .restore_req   (req),
        .we            (we),
        .write_address (wa),
        .data_In       (di),
        .read_address  (ra),
        .data_Out      (dout),
        .busy          (busy),
        .restore_done  (done),
        .pellets_left  (pl),
        .level_clear   (lvl)
    );

    function automatic logic [3:0] image_tile(input int i);
        int r;
        int c;
        r = i / 40;
        c = i % 40;
        if (r == 0 || r == 29 || c == 0 || c == 39) return 4'h3;
        if (r >= 1 && r <= 12 && c >= 1 && c <= 20) begin
            if (c == 20 && (r == 1 || r == 12)) return 4'h2;
            return 4'h1;
        end
        return 4'h0;
    endfunction

    function automatic bit is_p(input logic [3:0] t);
        return (t == 4'h1) || (t == 4'h2);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input logic [63:0] obs, input logic [63:0] expv, input string tag);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic load_model();
        for (int i = 0; i < DEPTH; i++) mem_m[i] = image_tile(i);
        cnt_m = 240;
    endtask

    // One idle cycle: optional write plus reads on all ports from ra_v.
    task automatic step(input logic w, input int a, input logic [3:0] d, input string tag);
        logic [3:0] old;
        we = w;
        wa = AW'(a);
        di = d;
        for (int k = 0; k < NR; k++) ra[k*AW +: AW] = AW'(ra_v[k]);
        if (w && a < DEPTH) begin
            old = mem_m[a];
            if (is_p(old) && !is_p(d) && cnt_m > 0) cnt_m--;
            else if (!is_p(old) && is_p(d) && cnt_m < DEPTH) cnt_m++;
            mem_m[a] = d;
        end
        for (int k = 0; k < NR; k++)
            exp_q.push_back((ra_v[k] < DEPTH) ? mem_m[ra_v[k]] : 4'h0);
        tick();
        we = 1'b0;
        for (int k = 0; k < NR; k++)
            chk(dout[k*DW +: DW], exp_q.pop_front(), $sformatf("%s_p%0d", tag, k));
        chk(pl, cnt_m, {tag, "_cnt"});
    endtask

    // Called with the first restore cycle already visible on busy.
    task automatic run_restore(input string tag, input bit poke);
        int cyc;
        cyc = 0;
        while (busy === 1'b1 && cyc < 3000) begin
            cyc++;
            if (cyc == 10)  chk(lvl, 0, {tag, "_lvl_busy"});
            if (cyc == 600) chk(dout, 0, {tag, "_dout_busy"});
            if (poke && cyc == 300) begin
                we = 1'b1;
                wa = 11'd41;
                di = 4'h0;
            end
            if (poke && cyc == 700) req = 1'b1;
            tick();
            we  = 1'b0;
            req = 1'b0;
        end
        chk(cyc, 1201, {tag, "_busy_len"});
        chk(done, 1, {tag, "_done_pulse"});
        chk(pl, 240, {tag, "_count"});
        chk(lvl, 0, {tag, "_lvl"});
        tick();
        chk(done, 0, {tag, "_done_end"});
        load_model();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < NR; k++) ra_v[k] = 0;
        load_model();

        // Reset state, then the power-up restore.
        rst = 1'b1;
        tick();
        chk(busy, 1, "rst_busy");
        chk(done, 0, "rst_done");
        chk(pl, 0, "rst_cnt");
        chk(dout, 0, "rst_dout");
        chk(lvl, 0, "rst_lvl");
        tick();
        rst = 1'b0;
        run_restore("t1", 1'b0);

        // Eat pellet at 41, read it back next cycle.
        for (int k = 0; k < NR; k++) ra_v[k] = k * 40 + 1;
        step(1'b1, 41, 4'h0, "t2_wr");
        ra_v[0] = 41;
        step(1'b0, 0, 4'h0, "t2_rd");

        // Write-first bypass and out-of-range reads.
        ra_v[3] = 85;
        ra_v[5] = 1200;
        ra_v[6] = 2047;
        ra_v[7] = 500;
        step(1'b1, 85, 4'h0, "t3_byp0");
        step(1'b1, 500, 4'h5, "t3_byp5");
        step(1'b1, 500, 4'h2, "t3_bypP");

        // Writes that must leave the count alone or be dropped.
        ra_v[0] = 110;
        ra_v[1] = 0;
        step(1'b1, 110, 4'h0, "t5_e_over_e");
        step(1'b1, 0, 4'h0, "t5_wall");
        step(1'b1, 1200, 4'h1, "t5_oor");
        step(1'b1, 2000, 4'h2, "t5_oor2");

        // Clear every remaining pellet with random reads alongside.
        for (int i = 0; i < DEPTH; i++) begin
            if (is_p(mem_m[i])) begin
                for (int k = 0; k < NR; k++) ra_v[k] = int'($urandom_range(0, 1299));
                step(1'b1, i, 4'h0, "t4_clr");
            end
        end
        chk(pl, 0, "t4_zero");
        chk(lvl, 1, "t4_clear");
        step(1'b1, 300, 4'h1, "t4_readd");
        chk(lvl, 0, "t4_uncleared");
        step(1'b1, 300, 4'h0, "t4_reclr");
        chk(lvl, 1, "t4_clear2");

        // Level restart, with a write and a second request during busy.
        req = 1'b1;
        tick();
        req = 1'b0;
        run_restore("t4_rst", 1'b1);
        for (int b = 0; b < DEPTH; b += NR) begin
            for (int k = 0; k < NR; k++) ra_v[k] = b + k;
            step(1'b0, 0, 4'h0, "t4_map");
        end

        // Reset in the middle of a restore restarts it cleanly.
        req = 1'b1;
        tick();
        req = 1'b0;
        for (int i = 0; i < 599; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_restore("t6", 1'b0);
        for (int k = 0; k < NR; k++) ra_v[k] = 40 + k * 41;
        step(1'b0, 0, 4'h0, "t6_rd");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
